// File: rtl/axis_sim_pkg.sv
// Shared constants for the simulation AXI4-Stream frame source: beat geometry,
// tuser field offsets, FSM encoding and NetFPGA one-hot port codes.
package axis_sim_pkg;

    localparam int BEAT_BYTES = 32;
    localparam int LANE_BYTES = 4;

    localparam int LEN_LSB = 0;
    localparam int SRC_LSB = 16;
    localparam int DST_LSB = 24;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [7:0] NF0  = 8'h01;
    localparam logic [7:0] DMA0 = 8'h02;
    localparam logic [7:0] NF1  = 8'h04;
    localparam logic [7:0] DMA1 = 8'h08;
    localparam logic [7:0] NF2  = 8'h10;
    localparam logic [7:0] DMA2 = 8'h20;
    localparam logic [7:0] NF3  = 8'h40;
    localparam logic [7:0] DMA3 = 8'h80;

    function automatic logic [15:0] clamp_len(input logic [15:0] len, input int lo, input int hi);
        if (int'(len) < lo) return 16'(lo);
        if (int'(len) > hi) return 16'(hi);
        return len;
    endfunction

endpackage

// File: rtl/axis_sim_keep_calc.sv
// Maps (frame length, beat index) to the byte-enable mask and end-of-frame flag.
module axis_sim_keep_calc
    import axis_sim_pkg::*;
#(
    parameter int BYTES = BEAT_BYTES
) (
    input  logic [15:0]      len,
    input  logic [5:0]       beat,
    output logic [BYTES-1:0] keep,
    output logic             last
);

    logic [15:0] last_beat;
    logic [15:0] rem;

    always_comb begin
        last_beat = 16'((32'(len) + BYTES - 1) / BYTES - 1);
        rem       = 16'(32'(len) % BYTES);
        last      = ({10'd0, beat} == last_beat);
        keep      = '0;
        // A partial final beat enables only the low rem bytes.
        for (int i = 0; i < BYTES; i++) begin
            keep[i] = !last || (rem == 16'd0) || (16'(i) < rem);
        end
    end

endmodule

// File: rtl/axis_sim_pkt_gen.sv
// Simulation-only AXI4-Stream source: emits a programmed burst of Ethernet-sized
// frames carrying NetFPGA tuser metadata, with optional idle gaps between frames.
module axis_sim_pkt_gen
    import axis_sim_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_MIN_LEN            = 60,
    parameter int C_MAX_LEN            = 1518
) (
    input  logic                              axis_aclk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [15:0]                       num_pkts,
    input  logic [15:0]                       pkt_len,
    input  logic [7:0]                        src_port,
    input  logic [7:0]                        gap_cycles,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic                              busy,
    output logic                              done,
    output logic [15:0]                       pkt_count
);

    localparam int BYTES = C_M_AXIS_DATA_WIDTH / 8;
    localparam int LANES = BYTES / LANE_BYTES;

    logic [1:0]  state_q, state_d;
    logic [15:0] num_q, num_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  src_q, src_d;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [5:0]  beat_q, beat_d;
    logic [15:0] pkt_count_q, pkt_count_d;

    logic [BYTES-1:0] keep;
    logic             last;
    logic             send;
    logic             fire;

    axis_sim_keep_calc #(.BYTES(BYTES)) u_keep_calc (
        .len  (len_q),
        .beat (beat_q),
        .keep (keep),
        .last (last)
    );

    assign send = (state_q == ST_SEND);
    assign fire = send && m_axis_tready;

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        len_d       = len_q;
        src_d       = src_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        beat_d      = beat_q;
        pkt_count_d = pkt_count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pkt_count_d = '0;
                    beat_d      = '0;
                    if (num_pkts != 16'd0) begin
                        num_d   = num_pkts;
                        len_d   = clamp_len(pkt_len, C_MIN_LEN, C_MAX_LEN);
                        src_d   = src_port;
                        gap_d   = gap_cycles;
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SEND: begin
                if (fire) begin
                    if (last) begin
                        beat_d      = '0;
                        pkt_count_d = pkt_count_q + 16'd1;
                        if (pkt_count_q + 16'd1 == num_q) begin
                            state_d = ST_DONE;
                        end else if (gap_q == 8'd0) begin
                            state_d = ST_SEND;
                        end else begin
                            gap_cnt_d = gap_q;
                            state_d   = ST_GAP;
                        end
                    end else begin
                        beat_d = beat_q + 6'd1;
                    end
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q - 8'd1;
                if (gap_cnt_q <= 8'd1) state_d = ST_SEND;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            num_q       <= '0;
            len_q       <= '0;
            src_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            beat_q      <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            len_q       <= len_d;
            src_q       <= src_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            beat_q      <= beat_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Outputs come straight from registered state, so they hold while stalled.
    always_comb begin
        m_axis_tdata = '0;
        for (int l = 0; l < LANES; l++) begin
            m_axis_tdata[32*l +: 32] = {pkt_count_q, 10'd0, beat_q};
        end
        for (int b = 0; b < BYTES; b++) begin
            if (!(send && keep[b])) m_axis_tdata[8*b +: 8] = 8'h00;
        end
        m_axis_tuser = '0;
        if (send) begin
            m_axis_tuser[LEN_LSB +: 16] = len_q;
            m_axis_tuser[SRC_LSB +: 8]  = src_q;
            m_axis_tuser[DST_LSB +: 8]  = 8'h00;
        end
    end

    assign m_axis_tkeep  = send ? keep : '0;
    assign m_axis_tlast  = send && last;
    assign m_axis_tvalid = send;
    assign busy          = (state_q == ST_SEND) || (state_q == ST_GAP);
    assign done          = (state_q == ST_DONE);
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_axis_sim_pkt_gen.sv
// Bench for axis_sim_pkt_gen: directed bursts, a beat-level reference model and
// literal checks on length boundaries, gaps, backpressure and reset.
module tb_axis_sim_pkt_gen;
    import axis_sim_pkg::*;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int KW = DW / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   num_pkts = '0;
    logic [15:0]   pkt_len = '0;
    logic [7:0]    src_port = '0;
    logic [7:0]    gap_cycles = '0;
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic [UW-1:0] tuser;
    logic          tvalid, tlast, tready, busy, done;
    logic [15:0]   pkt_count;
    bit            rdy_rand = 1'b0;

    int total = 0;
    int bad = 0;

    axis_sim_pkt_gen dut (
        .axis_aclk     (clk),
        .reset         (reset),
        .start         (start),
        .num_pkts      (num_pkts),
        .pkt_len       (pkt_len),
        .src_port      (src_port),
        .gap_cycles    (gap_cycles),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tuser  (tuser),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .busy          (busy),
        .done          (done),
        .pkt_count     (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference beat k of a burst, from frame length arithmetic.
    function automatic void model_beat(input int len, input int src, input int k,
                                       output logic [DW-1:0] d, output logic [KW-1:0] kp,
                                       output logic [UW-1:0] u, output logic l);
        int nb, s, b, nbytes;
        nb = (len + 31) / 32;
        s = k / nb;
        b = k % nb;
        nbytes = len - 32 * b;
        l = (nbytes <= 32);
        if (nbytes > 32) nbytes = 32;
        kp = '0;
        d = '0;
        for (int j = 0; j < KW; j++) if (j < nbytes) kp[j] = 1'b1;
        for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = {s[15:0], b[15:0]};
        for (int j = 0; j < KW; j++) if (!kp[j]) d[8*j +: 8] = 8'h00;
        u = '0;
        u[15:0] = len[15:0];
        u[23:16] = src[7:0];
    endfunction

    // Monitor / scoreboard state
    int m_n = 0, m_len = 60, m_src = 0, m_nb = 2, acc_idx = 0;
    int acc_total = 0, done_cnt = 0, vld_cnt = 0, last_gap = -1, gap_cnt = 0;
    bit in_gap = 1'b0, stall_q = 1'b0;
    logic [DW-1:0] sv_d;
    logic [KW-1:0] sv_k;
    logic [UW-1:0] sv_u;
    logic          sv_l;

    initial begin
        logic [DW-1:0] ed;
        logic [KW-1:0] ek;
        logic [UW-1:0] eu;
        logic          el;
        forever begin
            @(negedge clk);
            if (reset) begin
                acc_idx = 0;
                m_n = 0;
                stall_q = 1'b0;
                in_gap = 1'b0;
            end else begin
                if (start && !busy) begin
                    m_n = int'(num_pkts);
                    m_len = (pkt_len < 16'd60) ? 60 : (pkt_len > 16'd1518) ? 1518 : int'(pkt_len);
                    m_src = int'(src_port);
                    m_nb = (m_len + 31) / 32;
                    acc_idx = 0;
                    in_gap = 1'b0;
                    last_gap = -1;
                end
                if (stall_q) begin
                    chk("stall_valid", 256'(tvalid), 256'(1'b1));
                    chk("stall_data", 256'(tdata), 256'(sv_d));
                    chk("stall_keep", 256'(tkeep), 256'(sv_k));
                    chk("stall_user", 256'(tuser), 256'(sv_u));
                    chk("stall_last", 256'(tlast), 256'(sv_l));
                end
                if (in_gap) begin
                    if (tvalid) begin
                        last_gap = gap_cnt;
                        in_gap = 1'b0;
                    end else begin
                        gap_cnt++;
                    end
                end
                if (tvalid) vld_cnt++;
                if (done) done_cnt++;
                if (tvalid && tready) begin
                    acc_total++;
                    chk("beat_in_burst", 256'(acc_idx < m_n * m_nb), 256'(1'b1));
                    if (acc_idx < m_n * m_nb) begin
                        model_beat(m_len, m_src, acc_idx, ed, ek, eu, el);
                        chk("beat_data", 256'(tdata), 256'(ed));
                        chk("beat_keep", 256'(tkeep), 256'(ek));
                        chk("beat_user", 256'(tuser), 256'(eu));
                        chk("beat_last", 256'(tlast), 256'(el));
                    end
                    acc_idx++;
                    if (tlast) begin
                        in_gap = 1'b1;
                        gap_cnt = 0;
                    end
                end
                stall_q = tvalid && !tready;
                sv_d = tdata;
                sv_k = tkeep;
                sv_u = tuser;
                sv_l = tlast;
            end
        end
    end

    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int n, input int len, input int src, input int gap);
        num_pkts = 16'(n);
        pkt_len = 16'(len);
        src_port = 8'(src);
        gap_cycles = 8'(gap);
        start = 1'b1;
        tick;
        start = 1'b0;
        num_pkts = 16'hFFFF;
        pkt_len = 16'd300;
        src_port = 8'hAA;
        gap_cycles = 8'd9;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int cyc;
        cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i;
                break;
            end
        end
        chk(nm, 256'(cyc >= 0), 256'(1'b1));
    endtask

    initial begin
        int a0, d0, v0, found;

        // reset state
        repeat (3) tick;
        @(negedge clk);
        chk("rst_tvalid", 256'(tvalid), 256'(0));
        chk("rst_tdata", 256'(tdata), 256'(0));
        chk("rst_tkeep", 256'(tkeep), 256'(0));
        chk("rst_tuser", 256'(tuser), 256'(0));
        chk("rst_tlast", 256'(tlast), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_pkt_count", 256'(pkt_count), 256'(0));
        tick;
        reset = 1'b0;
        tick;

        // 64 bytes: two full beats
        go(1, 64, NF0, 0);
        @(negedge clk);
        chk("len64_latency_valid", 256'(tvalid), 256'(1));
        chk("len64_b0_keep", 256'(tkeep), 256'(32'hFFFFFFFF));
        chk("len64_b0_last", 256'(tlast), 256'(0));
        chk("len64_user_len", 256'(tuser[15:0]), 256'(16'd64));
        chk("len64_busy", 256'(busy), 256'(1));
        @(negedge clk);
        chk("len64_b1_last", 256'(tlast), 256'(1));
        chk("len64_b1_keep", 256'(tkeep), 256'(32'hFFFFFFFF));
        chk("len64_b1_lane0", 256'(tdata[31:0]), 256'(32'h00000001));
        @(negedge clk);
        chk("len64_done", 256'(done), 256'(1));
        chk("len64_busy_drop", 256'(busy), 256'(0));
        chk("len64_pkt_count", 256'(pkt_count), 256'(1));
        tick;

        // 65 bytes: one byte on the third beat
        go(1, 65, DMA0, 0);
        repeat (3) @(negedge clk);
        chk("len65_b2_keep", 256'(tkeep), 256'(32'h00000001));
        chk("len65_b2_last", 256'(tlast), 256'(1));
        chk("len65_b2_data", 256'(tdata), 256'(8'h02));
        wait_done("len65_done", 10);
        tick;

        // 10 bytes clamps up to 60
        go(1, 10, NF1, 0);
        @(negedge clk);
        chk("len10_user_len", 256'(tuser[15:0]), 256'(16'd60));
        chk("len10_user_src", 256'(tuser[23:16]), 256'(8'h04));
        @(negedge clk);
        chk("len10_last_keep", 256'(tkeep), 256'(32'h0FFFFFFF));
        chk("len10_last", 256'(tlast), 256'(1));
        wait_done("len10_done", 10);
        tick;

        // backpressure: 3 x 100 bytes = 12 beats
        a0 = acc_total;
        d0 = done_cnt;
        rdy_rand = 1'b1;
        go(3, 100, NF2, 0);
        wait_done("bp_done", 500);
        chk("bp_pkt_count", 256'(pkt_count), 256'(3));
        rdy_rand = 1'b0;
        repeat (4) tick;
        chk("bp_beats", 256'(acc_total - a0), 256'(12));
        chk("bp_done_once", 256'(done_cnt - d0), 256'(1));
        chk("bp_count_hold", 256'(pkt_count), 256'(3));

        // back-to-back frames, then 5 idle cycles between frames
        go(2, 64, DMA1, 0);
        wait_done("gap0_done", 50);
        chk("gap0_idle", 256'(last_gap), 256'(0));
        chk("gap0_pkt_count", 256'(pkt_count), 256'(2));
        tick;
        go(2, 64, NF3, 5);
        wait_done("gap5_done", 50);
        chk("gap5_idle", 256'(last_gap), 256'(5));
        tick;

        // empty burst
        v0 = vld_cnt;
        go(0, 64, NF0, 0);
        @(negedge clk);
        chk("empty_done", 256'(done), 256'(1));
        chk("empty_busy", 256'(busy), 256'(0));
        chk("empty_valid", 256'(tvalid), 256'(0));
        chk("empty_pkt_count", 256'(pkt_count), 256'(0));
        repeat (4) tick;
        chk("empty_no_valid", 256'(vld_cnt - v0), 256'(0));

        // reset on beat 1 of frame 2 (seq 1)
        go(3, 64, DMA2, 0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tvalid && tdata[31:0] == 32'h00010001) begin
                found = 1;
                break;
            end
        end
        chk("rstmid_reached", 256'(found), 256'(1));
        d0 = done_cnt;
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_valid", 256'(tvalid), 256'(0));
        chk("rstmid_last", 256'(tlast), 256'(0));
        chk("rstmid_busy", 256'(busy), 256'(0));
        chk("rstmid_pkt_count", 256'(pkt_count), 256'(0));
        chk("rstmid_data", 256'(tdata), 256'(0));
        tick;
        reset = 1'b0;
        repeat (3) tick;
        chk("rstmid_no_done", 256'(done_cnt - d0), 256'(0));

        // replay from seq 0; a start while busy is ignored
        a0 = acc_total;
        go(3, 64, DMA2, 0);
        @(negedge clk);
        chk("replay_valid", 256'(tvalid), 256'(1));
        chk("replay_seq0", 256'(tdata[31:0]), 256'(32'h00000000));
        tick;
        tick;
        num_pkts = 16'd1;
        pkt_len = 16'd200;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_done("replay_done", 100);
        chk("replay_pkt_count", 256'(pkt_count), 256'(3));
        repeat (3) tick;
        chk("replay_beats", 256'(acc_total - a0), 256'(6));
        chk("replay_idle", 256'(busy), 256'(0));

        repeat (2) tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
